ht16d35a_spi_scheduler: RTL and testbench
=========================================

# ht16d35a_spi_scheduler

Sequences and shares one `spi_controller_ht16d35a` instance between `NUM_REQ` independent requesters (e.g. frame-buffer refresh, brightness control, blink control).
- After reset it first plays a fixed power-up command list into all HT16D35A chips.
- It then grants the SPI controller round-robin, one complete multi-byte transaction at a time.
- It sits directly upstream of the SPI controller; the controller's activate/busy handshake is its only downstream dependency.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `NUM_SELECTS`, 2, chip-select width, matches the SPI controller
- `OUT_BYTES`, 8, max bytes per transaction, matches the SPI controller
- `OUT_BYTES_SZ`, `$clog2(OUT_BYTES)`, byte-count width
- `REQ_SZ`, `$clog2(NUM_REQ)`, grant-index width

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `NUM_REQ`: per-requester level request; held until the matching `req_ack`.
- `req_cs` in `[NUM_REQ][NUM_SELECTS]`: active-high chip enables per requester.
- `req_data` in `[NUM_REQ][OUT_BYTES][8]`: bytes per requester, byte 0 sent first.
- `req_count` in `[NUM_REQ][OUT_BYTES_SZ]`: byte count per requester.
- `req_ack` out `NUM_REQ`: one-cycle pulse when the request is latched; requester may change its inputs afterwards.
- `req_done` out `NUM_REQ`: one-cycle pulse when that requester's SPI transaction has finished.
- `init_done` out 1: high once the power-up list has completed; stays high until reset.
- `spi_activate` out 1: to the controller's `activate`.
- `spi_cs` out `NUM_SELECTS`: to `in_cs`.
- `spi_data` out `[OUT_BYTES][8]`: to `out_data`.
- `spi_count` out `OUT_BYTES_SZ`: to `out_count`.
- `spi_busy` in 1: from the controller's `busy`.

## Operation
Reset values (all outputs, while `reset_n` is low):
- `req_ack`, `req_done`, `init_done`, `spi_activate` = 0.
- `spi_cs`, `spi_data`, `spi_count` = 0.
- Round-robin pointer = `NUM_REQ-1`, so requester 0 has highest priority first.
- Init index = 0; state = S_SYNC.

States:
- **S_SYNC**: wait for `spi_busy`=0; the controller reports busy during its own reset. Then go to S_INIT if `INIT_LEN`>0, else set `init_done` and go to S_ARB.
- **S_INIT**: load `INIT_CMDS[idx]` onto `spi_*`, with `spi_cs` all-ones (broadcast). Go to S_ISSUE with the tag "init".
- **S_ARB**: ignore requests until `init_done`=1. Search `req_valid` starting at pointer+1 mod `NUM_REQ`; the first set bit wins.
  - On a win: latch that requester's cs/data/count into the `spi_*` registers, pulse `req_ack[g]`, store `g`, set pointer=`g`, go to S_ISSUE.
  - With no valid request, stay in S_ARB.
- **S_ISSUE**: hold `spi_activate`=1 until `spi_busy` is sampled 1, because the controller samples `activate` only once per half-bit tick. Then drop `spi_activate` and go to S_WAIT.
- **S_WAIT**: wait for `spi_busy`=0, then finish according to the tag:
  - User transaction: pulse `req_done[g]` and go to S_ARB.
  - Init transaction: increment idx. If idx now equals `INIT_LEN`, set `init_done` and go to S_ARB; otherwise go to S_INIT.

Rules:
- `spi_*` data/cs/count are stable from S_ISSUE entry until S_WAIT exit.
- Exactly one `req_ack` and one `req_done` per granted transaction, in that order; never two grants outstanding.
- A requester that drops `req_valid` before its ack is simply not granted; this is legal.
- A requester may re-assert `req_valid` in the cycle of its `req_done`. Fairness still rotates it behind the other pending requesters.
- `req_count`=0 is passed through unchanged. The scheduler does not interpret count.
- Asserting reset mid-transaction abandons it with no `req_done`. After release, S_SYNC absorbs the controller's busy-in-reset.

## Timing
- Grant latency: `req_valid` sampled in S_ARB at edge N → `req_ack` and `spi_activate` high in cycle N+1.
- Back-to-back turnaround:
  - `spi_busy` sampled low at edge M → `req_done` high in cycle M+1 (state is S_ARB in that cycle).
  - The next grant's ack comes no earlier than cycle M+2.
- The scheduler's own overhead per transaction is 3 cycles; SPI time is owned by the controller.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `ht16d35a_pkg` holds:
  - `typedef struct` `ht16d35a_cmd_t` {count, bytes[OUT_BYTES]}.
  - `INIT_LEN` and `INIT_CMDS[INIT_LEN]`: software reset, system mode, COM count, global brightness, display on.
  - The state enum `sched_state_t`.
- One sub-module, `rr_arbiter`: parameter `N`; inputs `valid[N]` and `ptr`; outputs `found` and `grant_idx`. It is combinational priority-rotate logic, reused elsewhere.

## Test plan
- **Power-up**: release reset with `spi_busy` held 1 for 50 cycles, then a model that stays busy 40 cycles per activate → `INIT_LEN` activations, all with `spi_cs`=2'b11, then `init_done`=1. No `req_ack` before `init_done`.
- **Single request**: `req_valid[2]`, cs=2'b01, count=3, bytes 8'hA0/8'h01/8'hFF → `req_ack[2]` one cycle later, `spi_data` matches, exactly one `req_done[2]` after busy falls.
- **Round-robin**: all four requesters valid continuously → grant order 0,1,2,3,0,1 with no repeats.
- **Slow accept**: the controller model asserts busy 15 cycles after activate → `spi_activate` held high exactly until busy seen, then 0.
- **Reset mid-transaction**: assert `reset_n`=0 during S_WAIT → all outputs at reset values, no `req_done`. After release, the init list replays.
- **Withdrawn request**: `req_valid[1]` pulsed for 1 cycle while another transaction is busy → requester 1 is never acked.

Source files
------------

// File: rtl/ht16d35a_pkg.sv
// Shared types and constants for the HT16D35A SPI scheduler.
//   ht16d35a_cmd_t : one SPI command (byte count + bytes, byte 0 sent first)
//   INIT_LEN/CMDS  : power-up list broadcast to every chip after reset
//   sched_state_t  : scheduler FSM states
package ht16d35a_pkg;

  localparam int CMD_BYTES = 8;
  localparam int CMD_CNT_W = 3;

  typedef struct packed {
    logic [CMD_CNT_W-1:0]      count;
    logic [CMD_BYTES-1:0][7:0] bytes;
  } ht16d35a_cmd_t;

  localparam int INIT_LEN   = 5;
  localparam int INIT_IDX_W = $clog2(INIT_LEN + 1);

  localparam ht16d35a_cmd_t INIT_CMDS [INIT_LEN] = '{
    '{count: 3'd1, bytes: 64'h0000_0000_0000_00CC},  // software reset
    '{count: 3'd2, bytes: 64'h0000_0000_0000_0135},  // system mode: oscillator on
    '{count: 3'd2, bytes: 64'h0000_0000_0000_0332},  // COM count
    '{count: 3'd2, bytes: 64'h0000_0000_0000_4037},  // global brightness
    '{count: 3'd2, bytes: 64'h0000_0000_0000_0335}   // display on
  };

  typedef enum logic [2:0] {
    S_SYNC,
    S_INIT,
    S_ARB,
    S_ISSUE,
    S_WAIT
  } sched_state_t;

endpackage

// File: rtl/ht16d35a_spi_scheduler_rr_arbiter.sv
// Combinational round-robin priority search.
//   valid     : request vector
//   ptr       : last winner; search starts at ptr+1 mod N
//   found     : any valid bit set
//   grant_idx : index of first set bit in rotated order
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] grant_idx
);

  function automatic logic [W-1:0] rot(input logic [W-1:0] p, input int i);
    return W'((int'(p) + i) % N);
  endfunction

  // Walk from lowest priority to highest so the nearest requester overrides.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = N; i >= 1; i--) begin
      if (valid[rot(ptr, i)]) begin
        found     = 1'b1;
        grant_idx = rot(ptr, i);
      end
    end
  end

endmodule

// File: rtl/ht16d35a_spi_scheduler.sv
// Shares one HT16D35A SPI controller between NUM_REQ requesters.
// After reset it broadcasts the power-up command list, then grants whole
// transactions round-robin.
//   req_valid/cs/data/count : per-requester request, held until req_ack
//   req_ack / req_done      : one-cycle pulses, request latched / finished
//   init_done               : power-up list complete
//   spi_activate/cs/data/count, spi_busy : controller handshake
module ht16d35a_spi_scheduler
  import ht16d35a_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_SELECTS  = 2,
  parameter int OUT_BYTES    = 8,
  parameter int OUT_BYTES_SZ = $clog2(OUT_BYTES),
  parameter int REQ_SZ       = $clog2(NUM_REQ)
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_REQ-1:0]                           req_valid,
  input  logic [NUM_REQ-1:0][NUM_SELECTS-1:0]          req_cs,
  input  logic [NUM_REQ-1:0][OUT_BYTES-1:0][7:0]       req_data,
  input  logic [NUM_REQ-1:0][OUT_BYTES_SZ-1:0]         req_count,
  output logic [NUM_REQ-1:0]                           req_ack,
  output logic [NUM_REQ-1:0]                           req_done,
  output logic                                         init_done,
  output logic                                         spi_activate,
  output logic [NUM_SELECTS-1:0]                       spi_cs,
  output logic [OUT_BYTES-1:0][7:0]                    spi_data,
  output logic [OUT_BYTES_SZ-1:0]                      spi_count,
  input  logic                                         spi_busy
);

  sched_state_t                r_state, w_state_nxt;
  logic [INIT_IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [REQ_SZ-1:0]           r_ptr, w_ptr_nxt;
  logic [REQ_SZ-1:0]           r_gnt, w_gnt_nxt;
  logic                        r_is_init, w_is_init_nxt;
  logic                        r_init_done, w_init_done_nxt;
  logic                        r_act, w_act_nxt;
  logic [NUM_SELECTS-1:0]      r_cs, w_cs_nxt;
  logic [OUT_BYTES-1:0][7:0]   r_data, w_data_nxt;
  logic [OUT_BYTES_SZ-1:0]     r_count, w_count_nxt;
  logic [NUM_REQ-1:0]          r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]          r_done, w_done_nxt;

  logic                        w_found;
  logic [REQ_SZ-1:0]           w_gidx;
  ht16d35a_cmd_t               w_cmd;

  rr_arbiter #(.N(NUM_REQ), .W(REQ_SZ)) u_arb (
    .valid     (req_valid),
    .ptr       (r_ptr),
    .found     (w_found),
    .grant_idx (w_gidx)
  );

  assign w_cmd = INIT_CMDS[r_idx];

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_is_init_nxt   = r_is_init;
    w_init_done_nxt = r_init_done;
    w_act_nxt       = r_act;
    w_cs_nxt        = r_cs;
    w_data_nxt      = r_data;
    w_count_nxt     = r_count;
    w_ack_nxt       = '0;
    w_done_nxt      = '0;
    case (r_state)
      // Controller holds busy while it is itself in reset.
      S_SYNC: begin
        if (!spi_busy) begin
          if (INIT_LEN > 0) begin
            w_state_nxt = S_INIT;
          end else begin
            w_init_done_nxt = 1'b1;
            w_state_nxt     = S_ARB;
          end
        end
      end
      S_INIT: begin
        w_cs_nxt      = '1;
        w_count_nxt   = OUT_BYTES_SZ'(w_cmd.count);
        for (int b = 0; b < OUT_BYTES; b++) begin
          w_data_nxt[b] = (b < CMD_BYTES) ? w_cmd.bytes[b] : 8'h00;
        end
        w_is_init_nxt = 1'b1;
        w_act_nxt     = 1'b1;
        w_state_nxt   = S_ISSUE;
      end
      S_ARB: begin
        if (r_init_done && w_found) begin
          w_cs_nxt      = req_cs[w_gidx];
          w_data_nxt    = req_data[w_gidx];
          w_count_nxt   = req_count[w_gidx];
          w_ack_nxt     = NUM_REQ'(1) << w_gidx;
          w_gnt_nxt     = w_gidx;
          w_ptr_nxt     = w_gidx;
          w_is_init_nxt = 1'b0;
          w_act_nxt     = 1'b1;
          w_state_nxt   = S_ISSUE;
        end
      end
      // Controller samples activate only on its half-bit tick, so keep it
      // up until busy proves the transaction was accepted.
      S_ISSUE: begin
        if (spi_busy) begin
          w_act_nxt   = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!spi_busy) begin
          if (r_is_init) begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == INIT_IDX_W'(INIT_LEN - 1)) begin
              w_init_done_nxt = 1'b1;
              w_state_nxt     = S_ARB;
            end else begin
              w_state_nxt = S_INIT;
            end
          end else begin
            w_done_nxt  = NUM_REQ'(1) << r_gnt;
            w_state_nxt = S_ARB;
          end
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_SYNC;
      r_idx       <= '0;
      r_ptr       <= REQ_SZ'(NUM_REQ - 1);
      r_gnt       <= '0;
      r_is_init   <= 1'b0;
      r_init_done <= 1'b0;
      r_act       <= 1'b0;
      r_cs        <= '0;
      r_data      <= '0;
      r_count     <= '0;
      r_ack       <= '0;
      r_done      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_is_init   <= w_is_init_nxt;
      r_init_done <= w_init_done_nxt;
      r_act       <= w_act_nxt;
      r_cs        <= w_cs_nxt;
      r_data      <= w_data_nxt;
      r_count     <= w_count_nxt;
      r_ack       <= w_ack_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign req_ack      = r_ack;
  assign req_done     = r_done;
  assign init_done    = r_init_done;
  assign spi_activate = r_act;
  assign spi_cs       = r_cs;
  assign spi_data     = r_data;
  assign spi_count    = r_count;

endmodule

// File: tb/tb_ht16d35a_spi_scheduler.sv
// Directed bench for ht16d35a_spi_scheduler with a simple busy-model controller.
module tb_ht16d35a_spi_scheduler;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [3:0]           req_valid;
  logic [3:0][1:0]      req_cs;
  logic [3:0][7:0][7:0] req_data;
  logic [3:0][2:0]      req_count;
  logic [3:0]           req_ack, req_done;
  logic                 init_done, spi_activate;
  logic [1:0]           spi_cs;
  logic [7:0][7:0]      spi_data;
  logic [2:0]           spi_count;
  logic                 spi_busy;

  always #5 clk = ~clk;

  ht16d35a_spi_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_cs(req_cs), .req_data(req_data), .req_count(req_count),
    .req_ack(req_ack), .req_done(req_done), .init_done(init_done),
    .spi_activate(spi_activate), .spi_cs(spi_cs), .spi_data(spi_data),
    .spi_count(spi_count), .spi_busy(spi_busy)
  );

  // Controller model: busy rises m_dly cycles after activate is seen, lasts m_len.
  logic m_force;
  int   m_dly, m_len;
  int   m_cnt;
  int   m_ph;
  logic m_busy;
  assign spi_busy = m_force | m_busy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= 0; m_cnt <= 0; m_busy <= 1'b0;
    end else begin
      case (m_ph)
        0: if (spi_activate) begin m_ph <= 1; m_cnt <= m_dly; end
        1: if (m_cnt <= 1) begin m_busy <= 1'b1; m_ph <= 2; m_cnt <= m_len; end
           else m_cnt <= m_cnt - 1;
        default: if (m_cnt <= 1) begin m_busy <= 1'b0; m_ph <= 0; end
                 else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  // Event monitor
  int         m_nact = 0, m_badcs = 0, m_early = 0;
  int         m_acks [4] = '{0, 0, 0, 0};
  int         m_dones[4] = '{0, 0, 0, 0};
  logic       m_prev_act = 1'b0;
  logic [1:0] m_gq[$];

  always @(negedge clk) begin
    if (spi_activate && !m_prev_act) begin
      m_nact <= m_nact + 1;
      if (!init_done && spi_cs != 2'b11) m_badcs <= m_badcs + 1;
    end
    m_prev_act <= spi_activate;
    if (|req_ack && !init_done) m_early <= m_early + 1;
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i]) begin
        m_acks[i] <= m_acks[i] + 1;
        m_gq.push_back(2'(i));
      end
      if (req_done[i]) m_dones[i] <= m_dones[i] + 1;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (req_ack[i]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (req_done[i]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (init_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (spi_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_ack"},   64'(req_ack),      64'h0);
    chk({p, "_done"},  64'(req_done),     64'h0);
    chk({p, "_init"},  64'(init_done),    64'h0);
    chk({p, "_act"},   64'(spi_activate), 64'h0);
    chk({p, "_cs"},    64'(spi_cs),       64'h0);
    chk({p, "_data"},  64'(spi_data),     64'h0);
    chk({p, "_count"}, 64'(spi_count),    64'h0);
  endtask

  bit ok;
  int base, a0, d1, hi, ovl;
  logic [1:0] rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    reset_n = 1'b0; req_valid = '0; req_cs = '0; req_data = '0; req_count = '0;
    m_force = 1'b1; m_dly = 1; m_len = 40;
    repeat (3) @(posedge clk); #1;
    check_reset_vals("rst");

    // Power-up with controller busy for 50 cycles
    reset_n = 1'b1;
    repeat (50) @(posedge clk); #1;
    chk("sync_hold_act", 64'(spi_activate), 64'h0);
    m_force = 1'b0;
    wait_init(ok);
    chk("init_timeout", 64'(ok), 64'h1);
    chk("init_nact", 64'(m_nact), 64'd5);
    chk("init_badcs", 64'(m_badcs), 64'd0);
    chk("init_last_data", 64'(spi_data), 64'h0335);
    chk("init_last_count", 64'(spi_count), 64'd2);

    // Round-robin: all valid, pointer starts at 3
    req_cs = {2'b11, 2'b10, 2'b01, 2'b11};
    req_count = {3'd1, 3'd2, 3'd3, 3'd4};
    base = m_gq.size();
    req_valid = 4'b1111;
    for (int c = 0; c < 2000 && m_gq.size() < base + 6; c++) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rr_count", 64'(m_gq.size() >= base + 6), 64'h1);
    for (int k = 0; k < 6; k++)
      if (base + k < m_gq.size()) chk($sformatf("rr_grant%0d", k), 64'(m_gq[base + k]), 64'(rr_exp[k]));
    wait_done(1, ok);
    chk("rr_done_to", 64'(ok), 64'h1);

    // Single request on requester 2, one-cycle grant latency
    req_cs[2] = 2'b01; req_count[2] = 3'd3; req_data[2] = 64'h0000_0000_00FF_01A0;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    chk("sr_ack", 64'(req_ack), 64'h4);
    chk("sr_act", 64'(spi_activate), 64'h1);
    chk("sr_data", 64'(spi_data), 64'h0000_0000_00FF_01A0);
    chk("sr_cs", 64'(spi_cs), 64'h1);
    chk("sr_count", 64'(spi_count), 64'd3);
    req_valid[2] = 1'b0;
    d1 = m_dones[2];
    wait_done(2, ok);
    chk("sr_done_to", 64'(ok), 64'h1);
    chk("sr_done_pulse", 64'(req_done), 64'h4);
    repeat (20) @(posedge clk); #1;
    chk("sr_done_once", 64'(m_dones[2] - d1), 64'd1);

    // Withdrawn request from 1 while requester 0 is busy
    a0 = m_acks[1];
    req_valid[0] = 1'b1;
    wait_ack(0, ok);
    chk("wd_ack0_to", 64'(ok), 64'h1);
    req_valid[0] = 1'b0;
    wait_busy(ok);
    chk("wd_busy_to", 64'(ok), 64'h1);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_done(0, ok);
    chk("wd_done0_to", 64'(ok), 64'h1);
    repeat (10) @(posedge clk); #1;
    chk("wd_no_ack1", 64'(m_acks[1] - a0), 64'd0);

    // Slow accept: busy rises 15 cycles after activate is seen
    m_dly = 15;
    req_valid[3] = 1'b1;
    wait_ack(3, ok);
    chk("sa_ack_to", 64'(ok), 64'h1);
    req_valid[3] = 1'b0;
    hi = spi_activate ? 1 : 0;
    ovl = (spi_activate && spi_busy) ? 1 : 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (!spi_activate) break;
      hi++;
      if (spi_busy) ovl++;
    end
    chk("sa_act_cycles", 64'(hi), 64'd17);
    chk("sa_overlap", 64'(ovl), 64'd1);
    chk("sa_busy_at_drop", 64'(spi_busy), 64'h1);
    wait_done(3, ok);
    chk("sa_done_to", 64'(ok), 64'h1);
    m_dly = 1;

    // Reset during S_WAIT
    req_valid[1] = 1'b1;
    wait_ack(1, ok);
    chk("rm_ack_to", 64'(ok), 64'h1);
    req_valid[1] = 1'b0;
    wait_busy(ok);
    chk("rm_busy_to", 64'(ok), 64'h1);
    repeat (5) @(posedge clk); #1;
    d1 = m_dones[1];
    m_force = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rm");
    repeat (3) @(posedge clk); #1;
    a0 = m_nact;
    reset_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    m_force = 1'b0;
    wait_init(ok);
    chk("rm_init_to", 64'(ok), 64'h1);
    chk("rm_replay_nact", 64'(m_nact - a0), 64'd5);
    repeat (5) @(posedge clk); #1;
    chk("rm_no_done", 64'(m_dones[1] - d1), 64'd0);
    chk("early_ack", 64'(m_early), 64'd0);
    chk("badcs_total", 64'(m_badcs), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
